mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_if.sv | 37 +++
 rtl/mux_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// mux_scan_if: request/handshake bundle between a consumer, the 8:1 enabled
// mux and the mux_scan_ctrl sequencer.
// The optional parity output exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_if;
    logic       start;
    logic       abort;
    logic       ack;
    logic       mux_o;
    logic       e;
    logic       s0;
    logic       s1;
    logic       s2;
    logic [7:0] word;
    logic       valid;
    logic       busy;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity;
`endif

    // consumer / stimulus side
    modport master (
        output start, abort, ack, mux_o,
        input  e, s0, s1, s2, word, valid, busy
`ifdef MUX_SCAN_PARITY_EN
        , input parity
`endif
    );

    // sequencer side
    modport slave (
        input  start, abort, ack, mux_o,
        output e, s0, s1, s2, word, valid, busy
`ifdef MUX_SCAN_PARITY_EN
        , output parity
`endif
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: on start, walks the 8:1 mux select through channels 0..7,
// holding each for SETTLE+1 cycles, samples the mux output on the last cycle
// of each channel and publishes the packed byte with a valid/ack handshake.
// Optional feature: define MUX_SCAN_PARITY_EN to add a registered parity
// output (XOR of all word bits) that updates together with word.
//
// state | meaning
// IDLE  | mux disabled, waiting for start
// SCAN  | mux enabled, select = channel counter, settling/sampling
// DONE  | word valid, waiting for ack; start and abort ignored
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_scan_if.slave bus
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] ch_q, ch_d;
    logic [3:0] cnt_q, cnt_d;
    // channel 7 goes straight from the mux into word, so only 0..6 are shadowed
    logic [6:0] shadow_q, shadow_d;
    logic [7:0] word_q, word_d;
    logic       valid_q, valid_d;
    logic       e_q, e_d;
    logic       busy_q, busy_d;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity_q, parity_d;
`endif

    // state and output registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 3'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 7'd0;
            word_q   <= 8'h00;
            valid_q  <= 1'b0;
            e_q      <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            e_q      <= e_d;
            busy_q   <= busy_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // next-state, counters and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = valid_q;
        e_d      = e_q;
        busy_d   = busy_q;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SCAN;
                    ch_d     = 3'd0;
                    cnt_d    = 4'd0;
                    shadow_d = 7'd0;
                    e_d      = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    // abort wins over a sample on the same edge
                    state_d  = IDLE;
                    ch_d     = 3'd0;
                    cnt_d    = 4'd0;
                    shadow_d = 7'd0;
                    e_d      = 1'b0;
                    busy_d   = 1'b0;
                end else if (cnt_q == SETTLE_CNT) begin
                    cnt_d = 4'd0;
                    if (ch_q == 3'd7) begin
                        word_d  = {bus.mux_o, shadow_q};
                        valid_d = 1'b1;
                        state_d = DONE;
                        ch_d    = 3'd0;
                        e_d     = 1'b0;
                        busy_d  = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
                        parity_d = bus.mux_o ^ (^shadow_q);
`endif
                    end else begin
                        shadow_d[ch_q] = bus.mux_o;
                        ch_d           = ch_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.e     = e_q;
    assign bus.s0    = ch_q[0];
    assign bus.s1    = ch_q[1];
    assign bus.s2    = ch_q[2];
    assign bus.word  = word_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: two sequencers (settle 1 and settle 0), each driving its
// own behavioural 8:1 mux. Expected select/timing/word values come from the
// scan rules: after start is taken, cycle j shows channel j/(settle+1), and
// the word equals the mux data byte 8*(settle+1) cycles later.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] abort_v;
    logic [1:0] ack_v;
    logic [7:0] data0;
    logic [7:0] data1;

    logic [7:0] exp_word  [2];
    bit         exp_valid [2];

    int n_chk;
    int n_fail;

    mux_scan_if b0();
    mux_scan_if b1();

    mux_scan_ctrl #(.SETTLE(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mux_scan_ctrl #(.SETTLE(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    assign b0.start = start_v[0];
    assign b0.abort = abort_v[0];
    assign b0.ack   = ack_v[0];
    assign b1.start = start_v[1];
    assign b1.abort = abort_v[1];
    assign b1.ack   = ack_v[1];

    // the 8:1 enabled mux: output is 0 whenever enable is low
    assign b0.mux_o = b0.e ? data0[{b0.s2, b0.s1, b0.s0}] : 1'b0;
    assign b1.mux_o = b1.e ? data1[{b1.s2, b1.s1, b1.s0}] : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int per_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic [7:0] o_e(input int d);
        return (d == 0) ? 8'(b0.e) : 8'(b1.e);
    endfunction
    function automatic logic [7:0] o_sel(input int d);
        return (d == 0) ? 8'({b0.s2, b0.s1, b0.s0}) : 8'({b1.s2, b1.s1, b1.s0});
    endfunction
    function automatic logic [7:0] o_busy(input int d);
        return (d == 0) ? 8'(b0.busy) : 8'(b1.busy);
    endfunction
    function automatic logic [7:0] o_valid(input int d);
        return (d == 0) ? 8'(b0.valid) : 8'(b1.valid);
    endfunction
    function automatic logic [7:0] o_word(input int d);
        return (d == 0) ? b0.word : b1.word;
    endfunction
`ifdef MUX_SCAN_PARITY_EN
    function automatic logic [7:0] o_par(input int d);
        return (d == 0) ? 8'(b0.parity) : 8'(b1.parity);
    endfunction
`endif

    // outputs while not scanning: mux off, result registers as the model says
    task automatic chk_quiet(input string tag, input int d);
        chk({tag, "_e"},     o_e(d),     8'd0);
        chk({tag, "_sel"},   o_sel(d),   8'd0);
        chk({tag, "_busy"},  o_busy(d),  8'd0);
        chk({tag, "_valid"}, o_valid(d), 8'(exp_valid[d]));
        chk({tag, "_word"},  o_word(d),  exp_word[d]);
`ifdef MUX_SCAN_PARITY_EN
        chk({tag, "_par"},   o_par(d),   8'(^exp_word[d]));
`endif
    endtask

    task automatic set_data(input int d, input logic [7:0] v);
        if (d == 0) data0 = v;
        else        data1 = v;
    endtask

    // one scan; abort_ch/rst_ch >= 0 cut it short on that channel
    task automatic do_scan(input int d, input logic [7:0] data, input int abort_ch,
                           input int rst_ch, input bit hold_start);
        int per;
        per = per_of(d);
        @(negedge clk);
        set_data(d, data);
        chk_quiet("idle", d);
        start_v[d] = 1'b1;
        @(negedge clk);
        if (!hold_start) start_v[d] = 1'b0;
        for (int j = 0; j < 8 * per; j++) begin
            chk("scan_sel",   o_sel(d),   8'(j / per));
            chk("scan_e",     o_e(d),     8'd1);
            chk("scan_busy",  o_busy(d),  8'd1);
            chk("scan_valid", o_valid(d), 8'(exp_valid[d]));
            chk("scan_word",  o_word(d),  exp_word[d]);
            if (rst_ch >= 0 && j == rst_ch * per) begin
                rst_n = 1'b0;
                #1;
                exp_word[0] = 8'h00; exp_valid[0] = 1'b0;
                exp_word[1] = 8'h00; exp_valid[1] = 1'b0;
                chk_quiet("rst0", 0);
                chk_quiet("rst1", 1);
                start_v[d] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (abort_ch >= 0 && j == abort_ch * per + per - 1) begin
                abort_v[d] = 1'b1;
                @(negedge clk);
                abort_v[d] = 1'b0;
                start_v[d] = 1'b0;
                chk_quiet("abort", d);
                return;
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        exp_word[d]  = data;
        exp_valid[d] = 1'b1;
        chk_quiet("done", d);
    endtask

    // sit in DONE, poke start/abort n times with new mux data, then ack
    task automatic do_ack(input int d, input int n_poke, input logic [7:0] new_data);
        set_data(d, new_data);
        for (int i = 0; i < n_poke; i++) begin
            start_v[d] = 1'b1;
            abort_v[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            chk_quiet("hold", d);
        end
        ack_v[d] = 1'b1;
        @(negedge clk);
        ack_v[d] = 1'b0;
        exp_valid[d] = 1'b0;
        chk_quiet("ack", d);
    endtask

    task automatic idle_abort(input int d);
        abort_v[d] = 1'b1;
        @(negedge clk);
        abort_v[d] = 1'b0;
        chk_quiet("idle_abort", d);
    endtask

    initial begin
        int d;
        int ab;
        logic [7:0] rd;
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start_v = 2'b00;
        abort_v = 2'b00;
        ack_v   = 2'b00;
        data0   = 8'h00;
        data1   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            exp_word[i]  = 8'h00;
            exp_valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_quiet("reset0", 0);
        chk_quiet("reset1", 1);
        rst_n = 1'b1;

        do_scan(0, 8'hA5, -1, -1, 1'b0);
        do_scan(1, 8'h3C, -1, -1, 1'b0);
        do_ack(1, 0, 8'h3C);
        do_ack(0, 3, 8'hFF);
        do_scan(0, 8'hFF, -1, -1, 1'b1);
        do_ack(0, 0, 8'h00);

        do_scan(0, 8'h0F, -1, -1, 1'b0);
        do_ack(0, 1, 8'h0F);
        do_scan(0, 8'hF0, 4, -1, 1'b0);
        idle_abort(0);

        do_scan(0, 8'h5A, -1, 5, 1'b0);
        do_scan(0, 8'h81, -1, -1, 1'b0);
        do_ack(0, 0, 8'h00);

        do_scan(1, 8'h07, -1, -1, 1'b0);
        do_ack(1, 1, 8'h03);
        do_scan(1, 8'h03, -1, -1, 1'b0);
        do_ack(1, 0, 8'h00);

        for (int it = 0; it < 16; it++) begin
            d  = int'($urandom_range(0, 1));
            rd = 8'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            if ($urandom_range(0, 3) == 0) idle_abort(d);
            do_scan(d, rd, ab, -1, 1'($urandom_range(0, 1)));
            if (ab < 0) do_ack(d, int'($urandom_range(0, 2)), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
